// File: rtl/poly_eval_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_eval_if
// Brief    : Coefficient-write, abscissa and result handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface poly_eval_if #(
  parameter int W = 32
);
  logic         coef_we;
  logic [1:0]   coef_idx;
  logic [W-1:0] coef_data;
  logic         x_valid;
  logic [W-1:0] x_data;
  logic         x_ready;
  logic         y_valid;
  logic [W-1:0] y_data;
  logic         y_ovf;
  logic         y_ready;
  logic         busy;

  modport master (
    output coef_we, coef_idx, coef_data, x_valid, x_data, y_ready,
    input  x_ready, y_valid, y_data, y_ovf, busy
  );

  modport slave (
    input  coef_we, coef_idx, coef_data, x_valid, x_data, y_ready,
    output x_ready, y_valid, y_data, y_ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/poly_eval.sv
`default_nettype none
// ============================================================================
// Module   : poly_eval
// Brief    : Cubic polynomial evaluator, Horner form, saturating fixed point.
// Revision : 1.0 - initial release
// ============================================================================
module poly_eval #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  wire logic   wb_clk_i,
  input  wire logic   wb_rst_i,
  poly_eval_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] c_SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] c_SAT_MIN = {1'b1, {(W-1){1'b0}}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [W-1:0]        r_coef [4];
  logic [W-1:0]        r_wc   [4];
  logic signed [W-1:0] r_x;
  logic signed [W-1:0] r_acc;
  logic [1:0]          r_cnt;
  logic                r_ovf;
  logic [W-1:0]        r_y_data;
  logic                r_y_ovf;

  logic                  w_accept;
  logic [W-1:0]          w_c_sel;
  logic signed [2*W-1:0] w_prod;
  logic signed [2*W-1:0] w_shift;
  logic signed [2*W:0]   w_sum;
  logic [W+1:0]          w_hi;
  logic                  w_sat;
  logic [W-1:0]          w_step;

  assign w_accept = bus.x_valid && (r_state == IDLE);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.x_valid)  w_state_nxt = CALC;
      CALC:    if (r_cnt == 2'd0) w_state_nxt = DONE;
      DONE:    if (bus.y_ready)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // One Horner step: full-width product, floor shift, then saturate back to W bits.
  assign w_c_sel = r_wc[r_cnt];
  assign w_prod  = r_acc * r_x;
  assign w_shift = w_prod >>> FRAC;
  assign w_sum   = {w_shift[2*W-1], w_shift} + {{(W+1){w_c_sel[W-1]}}, w_c_sel};
  assign w_hi    = w_sum[2*W:W-1];
  assign w_sat   = !((&w_hi) || !(|w_hi));
  assign w_step  = w_sat ? (w_sum[2*W] ? c_SAT_MIN : c_SAT_MAX) : w_sum[W-1:0];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 4; i++) r_coef[i] <= '0;
    end else if (bus.coef_we) begin
      r_coef[bus.coef_idx] <= bus.coef_data;
    end
  end

  // The snapshot reads r_coef before any same-edge write lands.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 4; i++) r_wc[i] <= '0;
      r_x      <= '0;
      r_acc    <= '0;
      r_cnt    <= 2'd0;
      r_ovf    <= 1'b0;
      r_y_data <= '0;
      r_y_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_x   <= bus.x_data;
      r_wc  <= r_coef;
      r_acc <= r_coef[3];
      r_cnt <= 2'd2;
      r_ovf <= 1'b0;
    end else if (r_state == CALC) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - 2'd1;
      r_ovf <= r_ovf | w_sat;
      if (r_cnt == 2'd0) begin
        r_y_data <= w_step;
        r_y_ovf  <= r_ovf | w_sat;
      end
    end
  end

  assign bus.x_ready = (r_state == IDLE);
  assign bus.busy    = (r_state != IDLE);
  assign bus.y_valid = (r_state == DONE);
  assign bus.y_data  = r_y_data;
  assign bus.y_ovf   = r_y_ovf;

endmodule
`default_nettype wire
